// File: rtl/padding.sv
// Streaming zero-padding stage: wraps a channel-fastest raster image in a border of pad words.
// Optional build macro PADDING_PAD_VALUE_EN selects PAD_VALUE instead of zero for border words.
module padding #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned IMG_WIDTH      = 4,
    parameter int unsigned IMG_HEIGHT     = 3,
    parameter int unsigned PADDING_WIDTH  = 3,
    parameter int unsigned PADDING_HEIGHT = 2,
    parameter int unsigned CHANNELS       = 2,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    input  logic                  data_out_ready
);

    localparam int unsigned PW_TOT = IMG_WIDTH + 2 * PADDING_WIDTH;
    localparam int unsigned PH_TOT = IMG_HEIGHT + 2 * PADDING_HEIGHT;
    localparam int unsigned CW     = $clog2(CHANNELS + 1);
    localparam int unsigned XW     = $clog2(PW_TOT + 1);
    localparam int unsigned YW     = $clog2(PH_TOT + 1);

`ifdef PADDING_PAD_VALUE_EN
    localparam logic [DATA_WIDTH-1:0] BORDER_WORD = PAD_VALUE;
`else
    // PAD_VALUE is masked off so the zero-border build ignores it.
    localparam logic [DATA_WIDTH-1:0] BORDER_WORD = PAD_VALUE & {DATA_WIDTH{1'b0}};
`endif

    logic [CW-1:0] c;
    logic [XW-1:0] x;
    logic [YW-1:0] y;

    logic c_last;
    logic x_last;
    logic y_last;
    logic x_inside;
    logic y_inside;
    logic interior;
    logic handshake;

    // Position decode; the +1 form keeps the lower-bound test meaningful when padding is zero.
    always_comb begin
        c_last   = (32'(c) == CHANNELS - 1);
        x_last   = (32'(x) == PW_TOT - 1);
        y_last   = (32'(y) == PH_TOT - 1);
        x_inside = ((32'(x) + 32'd1) > PADDING_WIDTH) && (32'(x) < PADDING_WIDTH + IMG_WIDTH);
        y_inside = ((32'(y) + 32'd1) > PADDING_HEIGHT) && (32'(y) < PADDING_HEIGHT + IMG_HEIGHT);
        interior = x_inside && y_inside;
    end

    // Zero-latency data path and handshakes; everything is quiet while reset is held.
    always_comb begin
        data_out       = '0;
        data_out_valid = 1'b0;
        data_in_ready  = 1'b0;
        if (rst) begin
            if (interior) begin
                data_out       = data_in;
                data_out_valid = data_in_valid;
                data_in_ready  = data_out_ready;
            end else begin
                data_out       = BORDER_WORD;
                data_out_valid = 1'b1;
            end
        end
    end

    assign handshake = data_out_valid && data_out_ready;

    // Output position counters: channel fastest, then column, then line; frames roll over seamlessly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c <= '0;
            x <= '0;
            y <= '0;
        end else if (handshake) begin
            if (c_last) begin
                c <= '0;
                if (x_last) begin
                    x <= '0;
                    y <= y_last ? '0 : y + YW'(1);
                end else begin
                    x <= x + XW'(1);
                end
            end else begin
                c <= c + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_padding.sv
// Self-checking bench for padding: randomized and directed streams against a frame-level reference model.
module tb_padding;

    localparam int unsigned DW   = 32;
    localparam int unsigned IW   = 4;
    localparam int unsigned IH   = 3;
    localparam int unsigned PWD  = 3;
    localparam int unsigned PHT  = 2;
    localparam int unsigned CH   = 2;
    localparam int unsigned PWT  = IW + 2 * PWD;
    localparam int unsigned PHTT = IH + 2 * PHT;
    localparam int unsigned NOUT = PWT * PHTT * CH;
    localparam int unsigned NIN  = IW * IH * CH;

`ifdef PADDING_PAD_VALUE_EN
    localparam logic [DW-1:0] BORDER = 32'hDEAD;
`else
    localparam logic [DW-1:0] BORDER = 32'h0;
`endif

    logic          clk;
    logic          rst;
    logic [DW-1:0] data_in;
    logic          data_in_valid;
    logic          data_in_ready;
    logic [DW-1:0] data_out;
    logic          data_out_valid;
    logic          data_out_ready;

    logic [DW-1:0] z_in;
    logic          z_in_valid;
    logic          z_in_ready;
    logic [DW-1:0] z_out;
    logic          z_out_valid;
    logic          z_out_ready;

    padding #(
        .DATA_WIDTH(DW), .IMG_WIDTH(IW), .IMG_HEIGHT(IH),
        .PADDING_WIDTH(PWD), .PADDING_HEIGHT(PHT), .CHANNELS(CH),
        .PAD_VALUE(32'hDEAD)
    ) dut (
        .clk(clk), .rst(rst),
        .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
        .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ready(data_out_ready)
    );

    padding #(
        .DATA_WIDTH(DW), .IMG_WIDTH(IW), .IMG_HEIGHT(IH),
        .PADDING_WIDTH(0), .PADDING_HEIGHT(0), .CHANNELS(CH),
        .PAD_VALUE(32'h0)
    ) dut0 (
        .clk(clk), .rst(rst),
        .data_in(z_in), .data_in_valid(z_in_valid), .data_in_ready(z_in_ready),
        .data_out(z_out), .data_out_valid(z_out_valid), .data_out_ready(z_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference frame: which padded positions are interior, and which input word each one carries.
    bit            is_int [NOUT];
    int            src    [NOUT];
    logic [DW-1:0] words  [NIN];
    int            p = 0;
    int            k = 0;
    int            frames_done = 0;
    bit            rnd_mode = 1'b0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic new_words(input bit rnd);
        for (int i = 0; i < int'(NIN); i++)
            words[i] = rnd ? $urandom : DW'(i + 1);
    endtask

    task automatic build_model();
        int n;
        n = 0;
        for (int yy = 0; yy < int'(PHTT); yy++)
            for (int xx = 0; xx < int'(PWT); xx++)
                for (int cc = 0; cc < int'(CH); cc++) begin
                    int idx;
                    idx = (yy * int'(PWT) + xx) * int'(CH) + cc;
                    is_int[idx] = (xx >= int'(PWD)) && (xx < int'(PWD + IW)) &&
                                  (yy >= int'(PHT)) && (yy < int'(PHT + IH));
                    src[idx] = is_int[idx] ? n : -1;
                    if (is_int[idx]) n++;
                end
    endtask

    // One clock of main-DUT stimulus and checking at the model's current output position.
    task automatic cycle(input bit vin, input bit rdy);
        bit ev;
        bit hs_in;
        @(negedge clk);
        data_in_valid  = vin;
        data_out_ready = rdy;
        data_in        = (k < int'(NIN)) ? words[k] : 32'hBAD0_0000;
        #1;
        if (is_int[p]) begin
            chk("int_valid", DW'(data_out_valid), DW'(vin));
            chk("int_ready", DW'(data_in_ready), DW'(rdy));
            if (vin) chk("int_data", data_out, words[src[p]]);
            ev    = vin;
            hs_in = vin && rdy;
        end else begin
            chk("border_valid", DW'(data_out_valid), 32'd1);
            chk("border_ready", DW'(data_in_ready), 32'd0);
            chk("border_data", data_out, BORDER);
            ev    = 1'b1;
            hs_in = 1'b0;
        end
        if (ev && rdy) begin
            p++;
            if (hs_in) k++;
            if (p == int'(NOUT)) begin
                chk("frame_inputs", DW'(k), DW'(NIN));
                p = 0;
                k = 0;
                frames_done++;
                new_words(rnd_mode);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        data_in_valid  = 1'b1;
        data_out_ready = 1'b1;
        data_in        = 32'h1234_5678;
        #1;
        chk({tag, "_valid"}, DW'(data_out_valid), 32'd0);
        chk({tag, "_ready"}, DW'(data_in_ready), 32'd0);
        chk({tag, "_data"}, data_out, 32'd0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        data_in_valid  = 1'b0;
        data_out_ready = 1'b0;
        rst            = 1'b1;
        p              = 0;
        k              = 0;
    endtask

    initial begin
        rst            = 1'b0;
        data_in        = '0;
        data_in_valid  = 1'b0;
        data_out_ready = 1'b0;
        z_in           = '0;
        z_in_valid     = 1'b0;
        z_out_ready    = 1'b0;
        build_model();
        new_words(1'b0);

        // Reset state: outputs quiet even with upstream/downstream asserting.
        check_reset_outputs("rst_init");
        check_reset_outputs("rst_init2");
        release_reset();

        // Two back-to-back directed frames at full throughput: must take exactly 2*NOUT cycles.
        frames_done = 0;
        for (int i = 0; i < 2 * int'(NOUT); i++) cycle(1'b1, 1'b1);
        chk("b2b_frames", DW'(frames_done), 32'd2);
        chk("b2b_pos", DW'(p), 32'd0);

        // Random backpressure and input gaps with random data.
        rnd_mode = 1'b1;
        new_words(1'b1);
        frames_done = 0;
        for (int i = 0; i < 4000 && frames_done < 2; i++)
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
        chk("rand_frames", DW'(frames_done), 32'd2);

        // Mid-frame reset after 60 outputs; frame restarts from position zero.
        rnd_mode = 1'b0;
        new_words(1'b0);
        for (int i = 0; i < 60; i++) cycle(1'b1, 1'b1);
        chk("pre_reset_pos", DW'(p), 32'd60);
        rst = 1'b0;
        check_reset_outputs("rst_mid");
        release_reset();
        new_words(1'b0);
        for (int i = 0; i < 60; i++) cycle(1'b1, 1'b1);
        chk("post_reset_pos", DW'(p), 32'd60);

        // Zero-padding instance is a pure pass-through.
        for (int i = 0; i < 40; i++) begin
            bit vz;
            bit rz;
            logic [DW-1:0] wz;
            vz = $urandom_range(0, 1) != 0;
            rz = $urandom_range(0, 1) != 0;
            wz = $urandom;
            @(negedge clk);
            z_in        = wz;
            z_in_valid  = vz;
            z_out_ready = rz;
            #1;
            chk("zp_data", z_out, wz);
            chk("zp_valid", DW'(z_out_valid), DW'(vz));
            chk("zp_ready", DW'(z_in_ready), DW'(rz));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
